xor_fold_accum: RTL and testbench

Parametrised, pipelined successor to the fixed 64-to-32 XOR folding cells. It runs NCH independent channels. Each IN_W-bit input word is XOR-folded down to OUT_W bits, and the folded words are XOR-accumulated over a multi-beat frame into a per-channel signature. The block sits between a streaming data source and a signature/compare stage, with valid/ready handshakes on both sides.

---
 rtl/xor_fold_accum.sv | 147 ++++++++++++++
 tb/tb_xor_fold_accum.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_fold_accum.sv
// xor_fold_accum: NCH independent channels. Each IN_W-bit beat is XOR-folded
// to OUT_W bits and XOR-accumulated over a frame of up to BEATS beats into a
// per-channel signature. The input and output sides both use a valid/ready
// handshake. A frame closes on in_last, or it auto-closes at BEATS beats.
// Optional build macro XFOLD_ROTATE_EN: the accumulator is rotated left by one
// bit before each XOR, which makes the signature depend on beat order.
module xor_fold_accum #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int NCH   = 2,
  parameter int BEATS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [NCH*IN_W-1:0]          in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [NCH*OUT_W-1:0]         out_data,
  output logic [$clog2(BEATS+1)-1:0]   out_beats,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int CW    = $clog2(BEATS+1);
  localparam int FOLDS = IN_W / OUT_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  typedef logic [NCH-1:0][OUT_W-1:0] sig_t;

`ifdef XFOLD_ROTATE_EN
  // Rotate left by one bit. For OUT_W = 1 the shift terms reduce to identity.
  function automatic logic [OUT_W-1:0] rotl1(input logic [OUT_W-1:0] v);
    return (v << 1) | (v >> (OUT_W-1));
  endfunction
`endif

  // Frame state
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  sig_t            r_acc;

  // Output register
  sig_t            r_out_data;
  logic [CW-1:0]   r_out_beats;
  logic            r_out_valid;

  // Combinational datapath and next-state signals
  sig_t            w_fold;
  sig_t            w_acc_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_close;
  state_t          w_state_d;
  logic [CW-1:0]   w_cnt_d;
  sig_t            w_acc_d;

  // Input is only blocked when a result is pending and the sink is not taking it.
  assign w_in_ready = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & w_in_ready;
  assign w_cnt_next = r_cnt + CW'(1);
  // A clear in the same cycle swallows the beat, so it can never close a frame.
  assign w_close    = w_accept & ~clear &
                      (in_last | (w_cnt_next == CW'(BEATS)));

  // Fold each channel's input word into OUT_W bits and form the accumulator update.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    w_fold     = '0;
    w_acc_next = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < FOLDS; k++) begin
        w_fold[c] = w_fold[c] ^ in_data[c*IN_W + k*OUT_W +: OUT_W];
      end
`ifdef XFOLD_ROTATE_EN
      w_acc_next[c] = rotl1(r_acc[c]) ^ w_fold[c];
`else
      w_acc_next[c] = r_acc[c] ^ w_fold[c];
`endif
    end
  end

  // Next-state logic for the frame FSM, the beat counter and the accumulators.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_acc_d   = r_acc;
    if (clear) begin
      w_state_d = ST_IDLE;
      w_cnt_d   = '0;
      w_acc_d   = '0;
    end else if (w_accept) begin
      if (w_close) begin
        w_state_d = ST_IDLE;
        w_cnt_d   = '0;
        w_acc_d   = '0;
      end else begin
        w_state_d = ST_ACCUM;
        w_cnt_d   = w_cnt_next;
        w_acc_d   = w_acc_next;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_acc   <= w_acc_d;
    end
  end

  // Output register: load on close, drop valid on a plain handshake.
  always_ff @(posedge clk) begin
    // NOTE: the result data is reset too, because zero data after reset is visible on the ports.
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_valid <= 1'b0;
    end else if (w_close) begin
      // A close can only happen while in_ready is high, so a held result is never overwritten.
      r_out_data  <= w_acc_next;
      r_out_beats <= w_cnt_next;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_xor_fold_accum.sv
// Testbench for xor_fold_accum using the default parameters.
// Directed stimulus pushes the expected result of each frame into a scoreboard
// queue. A monitor pops one entry and compares it on every output handshake.
module tb_xor_fold_accum;

  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int NCH   = 2;
  localparam int BEATS = 4;
  localparam int CW    = $clog2(BEATS+1);

  typedef struct {
    logic [NCH*OUT_W-1:0] data;
    logic [CW-1:0]        beats;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  clear;
  logic [NCH*IN_W-1:0]   in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [NCH*OUT_W-1:0]  out_data;
  logic [CW-1:0]         out_beats;
  logic                  out_valid;
  logic                  out_ready;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  xor_fold_accum #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .NCH  (NCH),
    .BEATS(BEATS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_beats(out_beats),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [NCH*OUT_W-1:0] d, input logic [CW-1:0] b);
    exp_t e;
    e.data  = d;
    e.beats = b;
    sb.push_back(e);
  endtask

  // Present one beat, then wait until it is accepted (bounded). Returns at posedge+1.
  task automatic drive_beat(input logic [IN_W-1:0] d0, input logic [IN_W-1:0] d1,
                            input logic last, input logic clr);
    logic rdy;
    logic accepted;
    in_data  = {d1, d0};
    in_valid = 1'b1;
    in_last  = last;
    clear    = clr;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) accepted = 1'b1;
    end
    if (!accepted) check("beat_accept_timeout", 128'(accepted), 128'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare each handshaked result against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got data %h beats %0d expected none", out_data, out_beats);
      end else begin
        e = sb.pop_front();
        check("out_data", 128'(out_data), 128'(e.data));
        check("out_beats", 128'(out_beats), 128'(e.beats));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [OUT_W-1:0] auto_ch0;
    int drain;

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_out_beats", 128'(out_beats), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Single-beat frame
    push_exp(64'hFFFFFFFF_88888888, 3'd1);
    drive_beat(64'h12345678_9ABCDEF0, 64'hFFFFFFFF_00000000, 1'b1, 1'b0);
    @(negedge clk);
    check("single_latency_valid", 128'(out_valid), 128'(1));
    idle(2);

    // Auto-close after BEATS beats, no in_last
`ifdef XFOLD_ROTATE_EN
    auto_ch0 = 32'h0000000F;
`else
    auto_ch0 = 32'h00000000;
`endif
    push_exp({32'h0, auto_ch0}, 3'd4);
    for (int i = 0; i < 4; i++) drive_beat(64'h00000001_00000000, 64'h0, 1'b0, 1'b0);
    idle(2);

    // Backpressure: result held stable while the sink stalls
    out_ready = 1'b0;
    push_exp(64'h10000001_00000007, 3'd1);
    drive_beat(64'h00000003_00000004, 64'h10000000_00000001, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_out_data_held", 128'(out_data), 128'(64'h10000001_00000007));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_released_valid", 128'(out_valid), 128'(0));
    check("bp_released_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    idle(1);

    // Back-to-back single-beat frames, one result per cycle
    for (int i = 0; i < 8; i++) begin
      push_exp({32'(32'hA0 + i), 32'(i + 1)}, 3'd1);
      in_data  = {32'(32'hA0 + i), 32'h0, 32'h0, 32'(i + 1)};
      in_valid = 1'b1;
      in_last  = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", 128'(in_ready), 128'(1));
      if (i > 0) check("b2b_out_valid", 128'(out_valid), 128'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("b2b_last_valid", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_run_ends", 128'(out_valid), 128'(0));
    idle(1);

    // Clear mid-frame with a beat in the same cycle
    drive_beat(64'h11111111_22222222, 64'h0000000_00000003, 1'b0, 1'b0);
    drive_beat(64'h11111111_22222222, 64'h0000000_00000003, 1'b0, 1'b0);
    drive_beat(64'hDEADBEEF_00000000, 64'h0, 1'b0, 1'b1);
    push_exp({32'h0, 32'h0000000F}, 3'd1);
    drive_beat(64'h0000000A_00000005, 64'h0, 1'b1, 1'b0);
    idle(2);

    // Reset with a pending output
    drive_beat(64'h00000100_00000000, 64'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive_beat(64'h00000000_00000011, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("pending_before_reset", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", 128'(out_valid), 128'(0));
    check("rst2_out_data", 128'(out_data), 128'(0));
    check("rst2_out_beats", 128'(out_beats), 128'(0));
    check("rst2_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Reset mid-frame: the next frame starts from a zero accumulator
    drive_beat(64'hFFFF0000_00000000, 64'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp({32'h0, 32'h00000021}, 3'd1);
    drive_beat(64'h00000000_00000021, 64'h0, 1'b1, 1'b0);
    idle(3);

    // Every expected result must have been delivered
    drain = 0;
    while (sb.size() != 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    check("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
